// File: rtl/adder_pipe_n.sv
// adder_pipe_n: pipelined WIDTH-bit add/sub with carry-out and signed overflow, valid/ready stream.
//   Carry chain split into STAGES registered slices of W = WIDTH/STAGES bits; latency STAGES cycles.
//   Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, ci, sub (input beat);
//          out_valid/out_ready, s, co, of (result beat).
//   Optional: define SATURATE_EN to clamp s to the signed limit when of = 1.
module adder_pipe_n #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             of
);
  localparam int W = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  logic             advance;
  logic             rv   [STAGES];
  logic             rc   [STAGES];
  logic [WIDTH-1:0] ra   [STAGES];
  logic [WIDTH-1:0] rb   [STAGES];
  logic [WIDTH-1:0] racc [STAGES];
  logic             dv   [STAGES];
  logic             dc   [STAGES];
  logic [WIDTH-1:0] da   [STAGES];
  logic [WIDTH-1:0] db   [STAGES];
  logic [WIDTH-1:0] dacc [STAGES];
  logic [W:0]       slc  [STAGES];
  logic             msb_c;
  logic             of_n;
  logic             of_r;
  logic [WIDTH-1:0] res;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = rv[L];
  assign s         = racc[L];
  assign co        = rc[L];
  assign of        = of_r;
  // Subtraction enters as a + ~b + ~ci; each stage adds its own slice on top of the
  // carry registered by the stage below, accumulating finished slices in dacc.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      dv[k]   = k == 0 ? in_valid : rv[k == 0 ? 0 : k - 1];
      da[k]   = k == 0 ? a : ra[k == 0 ? 0 : k - 1];
      db[k]   = k == 0 ? b ^ {WIDTH{sub}} : rb[k == 0 ? 0 : k - 1];
      dc[k]   = k == 0 ? ci ^ sub : rc[k == 0 ? 0 : k - 1];
      slc[k]  = {1'b0, da[k][k*W +: W]} + {1'b0, db[k][k*W +: W]} + {{W{1'b0}}, dc[k]};
      dacc[k] = (k == 0 ? '0 : racc[k == 0 ? 0 : k - 1]) | (WIDTH'(slc[k][W-1:0]) << (k*W));
    end
  end
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign msb_c = dacc[L][WIDTH-1] ^ da[L][WIDTH-1] ^ db[L][WIDTH-1];
  assign of_n  = msb_c ^ slc[L][W];
`ifdef SATURATE_EN
  // A wrapped MSB of 1 means the true result was positive, and vice versa.
  assign res = of_n ? {~dacc[L][WIDTH-1], {(WIDTH-1){dacc[L][WIDTH-1]}}} : dacc[L];
`else
  assign res = dacc[L];
`endif
  // Data registers only load on valid beats so the outputs keep their last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        rv[k]   <= 1'b0;
        rc[k]   <= 1'b0;
        ra[k]   <= '0;
        rb[k]   <= '0;
        racc[k] <= '0;
      end
      of_r <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        rv[k] <= dv[k];
        if (dv[k]) begin
          ra[k]   <= da[k];
          rb[k]   <= db[k];
          rc[k]   <= slc[k][W];
          racc[k] <= k == L ? res : dacc[k];
        end
      end
      if (dv[L]) of_r <= of_n;
    end
  end
endmodule

// File: tb/tb_adder_pipe_n.sv
// tb_adder_pipe_n: scoreboard bench for adder_pipe_n at WIDTH=8, STAGES=2
module tb_adder_pipe_n;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       op_ci = 1'b0;
  logic       op_sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] s;
  logic       co;
  logic       of;
  logic [9:0] exp_cur = '0;
  logic [9:0] sb [$];
  logic [9:0] e;
  logic [7:0] hs;
  logic       hco, hof;
  logic       held = 1'b0;
  logic       done = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_in = 0;
  int         n_out = 0;

  adder_pipe_n #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(op_a), .b(op_b), .ci(op_ci), .sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .of(of)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference from integer arithmetic: {s, co, of}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m);
    int t, u;
    logic [7:0] r;
    logic cy, ov;
    t  = m ? int'($signed(x)) - int'($signed(y)) - int'(c) : int'($signed(x)) + int'($signed(y)) + int'(c);
    u  = m ? int'(x) - int'(y) - int'(c) : int'(x) + int'(y) + int'(c);
    cy = m ? (u >= 0) : (u > 255);
    ov = (t > 127) || (t < -128);
    r  = u[7:0];
`ifdef SATURATE_EN
    if (ov) r = t > 0 ? 8'h7F : 8'h80;
`endif
    return {r, cy, ov};
  endfunction

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m, input logic [9:0] ev);
    int n;
    op_a = x; op_b = y; op_ci = c; op_sub = m; exp_cur = ev; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("send_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m);
    send(x, y, c, m, model(x, y, c, m));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      n_in -= sb.size();
      sb.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_s", {24'b0, s}, {24'b0, hs});
        check("hold_flags", {29'b0, out_valid, co, of}, {29'b0, 1'b1, hco, hof});
      end
      held = out_valid && !out_ready;
      hs = s; hco = co; hof = of;
      if (out_valid && !out_ready) check("in_ready_stall", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", {31'b0, out_valid}, 32'd0);
        else begin
          e = sb.pop_front();
          check("s", {24'b0, s}, {24'b0, e[9:2]});
          check("co_of", {30'b0, co, of}, {30'b0, e[1:0]});
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(exp_cur);
        n_in++;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check("rst_state", {20'b0, out_valid, in_ready, co, of, s}, {20'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
`ifdef SATURATE_EN
    send(8'h7F, 8'h01, 1'b0, 1'b0, {8'h7F, 1'b0, 1'b1});
    send(8'h80, 8'h01, 1'b0, 1'b1, {8'h80, 1'b1, 1'b1});
    send(8'h7F, 8'hFF, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b1});
`else
    send(8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
    send(8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});
    send(8'h7F, 8'hFF, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
`endif
    send(8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
    send(8'h0F, 8'h00, 1'b1, 1'b0, {8'h10, 1'b0, 1'b0});
    send(8'h00, 8'h01, 1'b0, 1'b1, {8'hFF, 1'b0, 1'b0});
    send(8'h00, 8'h00, 1'b1, 1'b1, {8'hFF, 1'b0, 1'b0});
    send(8'hFF, 8'hFF, 1'b1, 1'b0, {8'hFF, 1'b1, 1'b0});
    repeat (4) @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 6; i++) send_m(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, {8'h33, 1'b0, 1'b0});
    send(8'h44, 8'h55, 1'b0, 1'b0, {8'h99, 1'b0, 1'b1});
    rst = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_state", {20'b0, out_valid, in_ready, co, of, s}, {20'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'h01, 8'h02, 1'b1, 1'b0, {8'h04, 1'b0, 1'b0});
    check("lat_1", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1 check("lat_2", {31'b0, out_valid}, 32'd1);
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0 send_m(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", sb.size(), 32'd0);
    check("count", n_out, n_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
